// File: rtl/hwpe_stream_split_buffered.sv
// Wide-to-narrow HWPE stream splitter. Each DATA_WIDTH_IN beat is cut into
// NB_OUT_STREAMS slices (lane 0 = LSBs), each held in a one-entry output
// register so lanes drain independently of each other.
module hwpe_stream_split_buffered #(
    parameter  int unsigned DATA_WIDTH_OUT   = 8,
    parameter  int unsigned NB_OUT_STREAMS   = 2,
    parameter  int unsigned SKIP_EMPTY_LANES = 0,
    localparam int unsigned DATA_WIDTH_IN    = DATA_WIDTH_OUT * NB_OUT_STREAMS,
    localparam int unsigned STRB_WIDTH_OUT   = DATA_WIDTH_OUT / 8,
    localparam int unsigned STRB_WIDTH_IN    = DATA_WIDTH_IN / 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    // wide input stream
    input  logic                         push_i_valid,
    output logic                         push_i_ready,
    input  logic [DATA_WIDTH_IN-1:0]     push_i_data,
    input  logic [STRB_WIDTH_IN-1:0]     push_i_strb,
    // lane outputs, lane i occupies slice i of the packed data/strb vectors
    output logic [NB_OUT_STREAMS-1:0]    pop_o_valid,
    input  logic [NB_OUT_STREAMS-1:0]    pop_o_ready,
    output logic [DATA_WIDTH_IN-1:0]     pop_o_data,
    output logic [STRB_WIDTH_IN-1:0]     pop_o_strb,
    output logic                         busy_o,
    output logic [31:0]                  beat_cnt_o
);

    logic [NB_OUT_STREAMS-1:0] full_q;
    logic [NB_OUT_STREAMS-1:0] full_d;
    logic [NB_OUT_STREAMS-1:0] free;
    logic [NB_OUT_STREAMS-1:0] lane_en;
    logic [NB_OUT_STREAMS-1:0] load;
    logic [DATA_WIDTH_IN-1:0]  data_q;
    logic [DATA_WIDTH_IN-1:0]  data_mask;
    logic [STRB_WIDTH_IN-1:0]  strb_q;
    logic [STRB_WIDTH_IN-1:0]  strb_mask;
    logic [31:0]               beat_cnt_q;
    logic                      accept;

    if (DATA_WIDTH_OUT % 8 != 0) begin : g_bad_width
        $error("DATA_WIDTH_OUT must be a multiple of 8");
    end

    // Per-lane enable and bit masks; loading is done with one masked
    // register update so every state bit has a single driving process.
    for (genvar g = 0; g < NB_OUT_STREAMS; g++) begin : g_lane
        if (SKIP_EMPTY_LANES != 0) begin : g_skip
            assign lane_en[g] = |push_i_strb[g*STRB_WIDTH_OUT +: STRB_WIDTH_OUT];
        end else begin : g_noskip
            assign lane_en[g] = 1'b1;
        end
        assign data_mask[g*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] = {DATA_WIDTH_OUT{load[g]}};
        assign strb_mask[g*STRB_WIDTH_OUT +: STRB_WIDTH_OUT] = {STRB_WIDTH_OUT{load[g]}};

        // Held lane output must not change until it is popped.
        a_pop_stable: assert property (@(posedge clk_i)
            (!rst_i && !clear_i && pop_o_valid[g] && !pop_o_ready[g]) |=>
                ($stable(pop_o_data[g*DATA_WIDTH_OUT +: DATA_WIDTH_OUT]) &&
                 $stable(pop_o_strb[g*STRB_WIDTH_OUT +: STRB_WIDTH_OUT])));
    end

    // Handshake and next-state flags; ready depends only on lane state and pop ready.
    always_comb begin
        free         = ~full_q | pop_o_ready;
        push_i_ready = &free;
        accept       = push_i_valid & push_i_ready;
        load         = {NB_OUT_STREAMS{accept}} & lane_en;
        full_d       = load | (full_q & ~pop_o_ready);
    end

    // Lane registers and beat counter; reset/clear wins over any handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            full_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= (data_q & ~data_mask) | (push_i_data & data_mask);
            strb_q <= (strb_q & ~strb_mask) | (push_i_strb & strb_mask);
            if (accept) begin
                beat_cnt_q <= beat_cnt_q + 32'd1;
            end
        end
    end

    assign pop_o_valid = full_q;
    assign pop_o_data  = data_q;
    assign pop_o_strb  = strb_q;
    assign busy_o      = |full_q;
    assign beat_cnt_o  = beat_cnt_q;

endmodule

// File: tb/tb_hwpe_stream_split_buffered.sv
// Bench for hwpe_stream_split_buffered: NB=2, W=8. Instance dut_a keeps all
// lanes, dut_s skips empty-strobe lanes. A lane scoreboard is filled on input
// handshakes and drained on output handshakes; scenario tasks add direct checks.
module tb_hwpe_stream_split_buffered;

    logic clk;
    logic rst;
    logic clear;

    logic        a_pv, a_pr, a_busy;
    logic [15:0] a_pd, a_od;
    logic [1:0]  a_ps, a_ov, a_or, a_os;
    logic [31:0] a_cnt;

    logic        s_pv, s_pr, s_busy;
    logic [15:0] s_pd, s_od;
    logic [1:0]  s_ps, s_ov, s_or, s_os;
    logic [31:0] s_cnt;

    typedef logic [8:0] ent_t;
    ent_t sb [4][$];

    int   tests  = 0;
    int   errors = 0;
    logic a_acc_last = 1'b0;

    hwpe_stream_split_buffered #(
        .DATA_WIDTH_OUT  (8),
        .NB_OUT_STREAMS  (2),
        .SKIP_EMPTY_LANES(0)
    ) dut_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .push_i_valid (a_pv),
        .push_i_ready (a_pr),
        .push_i_data  (a_pd),
        .push_i_strb  (a_ps),
        .pop_o_valid  (a_ov),
        .pop_o_ready  (a_or),
        .pop_o_data   (a_od),
        .pop_o_strb   (a_os),
        .busy_o       (a_busy),
        .beat_cnt_o   (a_cnt)
    );

    hwpe_stream_split_buffered #(
        .DATA_WIDTH_OUT  (8),
        .NB_OUT_STREAMS  (2),
        .SKIP_EMPTY_LANES(1)
    ) dut_s (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .push_i_valid (s_pv),
        .push_i_ready (s_pr),
        .push_i_data  (s_pd),
        .push_i_strb  (s_ps),
        .pop_o_valid  (s_ov),
        .pop_o_ready  (s_or),
        .pop_o_data   (s_od),
        .pop_o_strb   (s_os),
        .busy_o       (s_busy),
        .beat_cnt_o   (s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lane8(input logic [15:0] d, input int l);
        return 8'(d >> (8 * l));
    endfunction

    function automatic logic lane1(input logic [1:0] s, input int l);
        return 1'(s >> l);
    endfunction

    task automatic mon(input int k, input logic skip,
                       input logic pv, input logic pr,
                       input logic [15:0] pd, input logic [1:0] ps,
                       input logic [1:0] ov, input logic [1:0] orr,
                       input logic [15:0] od, input logic [1:0] os);
        ent_t got;
        ent_t exp;
        for (int l = 0; l < 2; l++) begin
            if (lane1(ov, l) && lane1(orr, l)) begin
                got = {lane1(os, l), lane8(od, l)};
                tests++;
                if (sb[k*2+l].size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop inst%0d lane%0d: got %h, required no output", k, l, got);
                end else begin
                    exp = sb[k*2+l].pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL sb_pop inst%0d lane%0d: got %h, required %h", k, l, got, exp);
                    end
                end
            end
        end
        if (pv && pr) begin
            for (int l = 0; l < 2; l++) begin
                if (!skip || lane1(ps, l))
                    sb[k*2+l].push_back({lane1(ps, l), lane8(pd, l)});
            end
        end
    endtask

    // Handshakes are sampled mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        if (rst || clear) begin
            for (int q = 0; q < 4; q++) sb[q].delete();
            a_acc_last = 1'b0;
        end else begin
            a_acc_last = a_pv && a_pr;
            mon(0, 1'b0, a_pv, a_pr, a_pd, a_ps, a_ov, a_or, a_od, a_os);
            mon(1, 1'b1, s_pv, s_pr, s_pd, s_ps, s_ov, s_or, s_od, s_os);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; clear = 1'b0;
        a_pv = 1'b0; a_pd = '0; a_ps = '0; a_or = 2'b11;
        s_pv = 1'b0; s_pd = '0; s_ps = '0; s_or = 2'b11;
        tick(2);
        tests++; if (a_ov !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b, required 00", a_ov); end
        tests++; if (a_od !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h, required 0000", a_od); end
        tests++; if (a_os !== 2'b00) begin errors++; $display("FAIL reset_strb: got %b, required 00", a_os); end
        tests++; if (a_pr !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", a_pr); end
        tests++; if (a_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d, required 0", a_cnt); end
        tests++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", a_busy); end
        tests++; if (s_pr !== 1'b1) begin errors++; $display("FAIL reset_ready_s: got %b, required 1", s_pr); end
        rst = 1'b0;
    endtask

    task automatic test_streaming;
        a_or = 2'b11; a_pv = 1'b1; a_pd = 16'h1122; a_ps = 2'b11;
        #1;
        tests++; if (a_pr !== 1'b1) begin errors++; $display("FAIL stream_ready: got %b, required 1", a_pr); end
        tick(1);
        tests++; if (a_ov !== 2'b11 || a_od !== 16'h1122) begin errors++; $display("FAIL stream_beat1: got v=%b d=%h, required v=11 d=1122", a_ov, a_od); end
        a_pd = 16'h3344;
        tick(1);
        tests++; if (a_ov !== 2'b11 || a_od !== 16'h3344) begin errors++; $display("FAIL stream_beat2: got v=%b d=%h, required v=11 d=3344", a_ov, a_od); end
        tests++; if (a_cnt !== 32'd2) begin errors++; $display("FAIL stream_cnt: got %0d, required 2", a_cnt); end
        a_pv = 1'b0;
        tick(1);
        tests++; if (a_ov !== 2'b00 || a_busy !== 1'b0) begin errors++; $display("FAIL stream_drain: got v=%b busy=%b, required v=00 busy=0", a_ov, a_busy); end
    endtask

    task automatic test_skew;
        a_or = 2'b01; a_pv = 1'b1; a_pd = 16'hAABB; a_ps = 2'b11;
        tick(1);
        tests++; if (a_ov !== 2'b11 || a_od !== 16'hAABB) begin errors++; $display("FAIL skew_load: got v=%b d=%h, required v=11 d=AABB", a_ov, a_od); end
        a_pd = 16'hCCDD;
        #1;
        tests++; if (a_pr !== 1'b0) begin errors++; $display("FAIL skew_block: got %b, required 0", a_pr); end
        tick(1);
        tests++; if (a_ov !== 2'b10 || a_od[15:8] !== 8'hAA || a_pr !== 1'b0) begin errors++; $display("FAIL skew_stall1: got v=%b d1=%h r=%b, required v=10 d1=AA r=0", a_ov, a_od[15:8], a_pr); end
        tick(1);
        tests++; if (a_ov !== 2'b10 || a_od[15:8] !== 8'hAA || a_pr !== 1'b0) begin errors++; $display("FAIL skew_stall2: got v=%b d1=%h r=%b, required v=10 d1=AA r=0", a_ov, a_od[15:8], a_pr); end
        a_or = 2'b11;
        #1;
        tests++; if (a_pr !== 1'b1) begin errors++; $display("FAIL skew_release: got %b, required 1", a_pr); end
        tick(1);
        tests++; if (a_ov !== 2'b11 || a_od !== 16'hCCDD) begin errors++; $display("FAIL skew_beat2: got v=%b d=%h, required v=11 d=CCDD", a_ov, a_od); end
        a_pv = 1'b0;
        tick(1);
        tests++; if (a_ov !== 2'b00 || a_cnt !== 32'd4) begin errors++; $display("FAIL skew_end: got v=%b cnt=%0d, required v=00 cnt=4", a_ov, a_cnt); end
    endtask

    task automatic test_skip_empty;
        s_or = 2'b11; s_pv = 1'b1; s_pd = 16'h5566; s_ps = 2'b10;
        tick(1);
        tests++; if (s_ov !== 2'b10 || s_od[15:8] !== 8'h55 || s_os !== 2'b10) begin errors++; $display("FAIL skip_partial: got v=%b d1=%h s=%b, required v=10 d1=55 s=10", s_ov, s_od[15:8], s_os); end
        s_pd = 16'h7788; s_ps = 2'b00;
        tick(1);
        tests++; if (s_ov !== 2'b00 || s_cnt !== 32'd2) begin errors++; $display("FAIL skip_empty: got v=%b cnt=%0d, required v=00 cnt=2", s_ov, s_cnt); end
        s_pv = 1'b0;
        tick(1);
        tests++; if (s_busy !== 1'b0 || s_cnt !== 32'd2) begin errors++; $display("FAIL skip_idle: got busy=%b cnt=%0d, required busy=0 cnt=2", s_busy, s_cnt); end
    endtask

    task automatic test_clear;
        a_or = 2'b00; a_pv = 1'b1; a_pd = 16'h1234; a_ps = 2'b11;
        tick(1);
        a_pd = 16'h5678;
        #1;
        tests++; if (a_pr !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL clear_stalled: got r=%b busy=%b, required r=0 busy=1", a_pr, a_busy); end
        tick(1);
        clear = 1'b1; a_or = 2'b11;
        tick(1);
        clear = 1'b0;
        tests++; if (a_ov !== 2'b00 || a_od !== 16'h0000 || a_cnt !== 32'd0 || a_busy !== 1'b0) begin errors++; $display("FAIL clear_state: got v=%b d=%h cnt=%0d busy=%b, required v=00 d=0000 cnt=0 busy=0", a_ov, a_od, a_cnt, a_busy); end
        tests++; if (a_pr !== 1'b1) begin errors++; $display("FAIL clear_ready: got %b, required 1", a_pr); end
        tick(1);
        tests++; if (a_ov !== 2'b11 || a_od !== 16'h5678 || a_cnt !== 32'd1) begin errors++; $display("FAIL clear_after: got v=%b d=%h cnt=%0d, required v=11 d=5678 cnt=1", a_ov, a_od, a_cnt); end
        a_pv = 1'b0;
        tick(1);
    endtask

    task automatic test_back_to_back;
        int acc;
        acc = 0;
        for (int c = 0; c < 300; c++) begin
            if (!(a_pv && !a_acc_last)) begin
                a_pv = ($urandom_range(0, 3) != 0);
                a_pd = 16'($urandom);
                a_ps = 2'($urandom);
            end
            a_or = 2'($urandom);
            tick(1);
            if (a_acc_last) acc++;
        end
        a_pv = 1'b0; a_or = 2'b11;
        tick(3);
        tests++; if (sb[0].size() != 0 || sb[1].size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d/%0d entries, required 0/0", sb[0].size(), sb[1].size()); end
        tests++; if (a_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b, required 0", a_busy); end
        tests++; if (acc == 0) begin errors++; $display("FAIL b2b_progress: got %0d accepts, required >0", acc); end
    endtask

    task automatic test_counter_wrap;
        force dut_a.beat_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut_a.beat_cnt_q;
        #1;
        tests++; if (a_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preset: got %h, required ffffffff", a_cnt); end
        a_or = 2'b11; a_pv = 1'b1; a_pd = 16'h0F0F; a_ps = 2'b11;
        tick(1);
        a_pv = 1'b0;
        tests++; if (a_cnt !== 32'h0000_0000) begin errors++; $display("FAIL wrap: got %h, required 00000000", a_cnt); end
        tick(2);
        tests++; if (a_cnt !== 32'h0000_0000) begin errors++; $display("FAIL wrap_hold: got %h, required 00000000", a_cnt); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skew();
        test_skip_empty();
        test_clear();
        test_back_to_back();
        test_counter_wrap();
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
